// File: rtl/serial_subtractor_32bit.sv
// serial_subtractor_32bit
//   Slice-serial subtractor: diff = a - b - b_in (mod 2^WIDTH), SLICE bits per clock through a
//   registered borrow chain. Operands are accepted with a valid/ready handshake and the result is
//   held under out_valid until out_ready consumes it. Latency: out_valid is visible after the
//   WIDTH/SLICE-th edge following the accept edge; no overlap between operations.
//
//   Optional macro SUB_ADD_MODE_EN: adds port op (captured with the operands); op = 1 computes
//   a + b + b_in, with b_out reporting carry-out and ovf using the addition overflow rule.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands present          in_ready   block can accept operands (IDLE)
//   a, b       minuend / subtrahend      b_in       borrow-in (carry-in when op = 1)
//   op         0 = subtract, 1 = add (only with SUB_ADD_MODE_EN)
//   out_valid  result valid (DONE)       out_ready  consumer accepts result
//   diff       result                    b_out      borrow-out (carry-out when op = 1)
//   zero       diff == 0                 ovf        signed overflow
module serial_subtractor_32bit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
`ifdef SUB_ADD_MODE_EN
  input  logic             op,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             zero,
  output logic             ovf
);

  if ((WIDTH % SLICE) != 0) begin : gen_width_check
    $error("serial_subtractor_32bit: WIDTH must be a multiple of SLICE");
  end

  localparam int unsigned NumSlices = WIDTH / SLICE;
  localparam int unsigned CntW      = (NumSlices > 1) ? $clog2(NumSlices) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NumSlices - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q;
  logic [WIDTH-1:0] a_q, b_q, diff_q, diff_d;
  logic             borrow_q;
  logic [CntW-1:0]  cnt_q;
  logic             b_out_q, zero_q, ovf_q;
  logic             op_q;
  logic             op_add;
  logic [SLICE-1:0] a_sl, b_sl;
  logic [SLICE:0]   slice_res;
  logic             ovf_d;

`ifdef SUB_ADD_MODE_EN
  assign op_add = op;
`else
  assign op_add = 1'b0;
`endif

  // Slice arithmetic and next partial result. In add mode borrow_q carries the carry bit; in both
  // modes the extra top bit of the (SLICE+1)-bit result is the chain bit for the next slice.
  always_comb begin
    a_sl      = a_q[cnt_q*SLICE +: SLICE];
    b_sl      = b_q[cnt_q*SLICE +: SLICE];
    slice_res = '0;
    if (op_q) begin
      slice_res = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, borrow_q};
    end else begin
      slice_res = {1'b0, a_sl} - {1'b0, b_sl} - {{SLICE{1'b0}}, borrow_q};
    end
    diff_d = diff_q;
    diff_d[cnt_q*SLICE +: SLICE] = slice_res[SLICE-1:0];
    if (op_q) begin
      ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (diff_d[WIDTH-1] != a_q[WIDTH-1]);
    end else begin
      ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_d[WIDTH-1] != a_q[WIDTH-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 1'b0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      b_out_q  <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            op_q     <= op_add;
            borrow_q <= b_in;
            cnt_q    <= '0;
            diff_q   <= '0;
            state_q  <= StCalc;
          end
        end
        StCalc: begin
          diff_q   <= diff_d;
          borrow_q <= slice_res[SLICE];
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            b_out_q <= slice_res[SLICE];
            zero_q  <= (diff_d == '0);
            ovf_q   <= ovf_d;
            state_q <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign diff      = diff_q;
  assign b_out     = b_out_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;

endmodule

// File: doc/serial_subtractor_32bit.md
Name: serial_subtractor_32bit

Overview:
- Multi-cycle, slice-serial 32-bit subtractor with borrow-in and borrow-out. It is the inverse-direction companion to the team's 32-bit ripple-carry adder.
- Computes diff = a - b - b_in, processing SLICE bits per clock through a registered borrow chain.
- Valid/ready handshake on both the operand side and the result side. The result is held until it is consumed.
- Sits in the ALU datapath where area matters more than latency.

Parameters:
WIDTH, 32, operand and result width in bits.
SLICE, 4, bits processed per clock; WIDTH % SLICE != 0 is an elaboration error.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  operands present
in_ready  output  1  block can accept operands
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
b_in  input  1  borrow-in
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
diff  output  WIDTH  a - b - b_in, mod 2^WIDTH
b_out  output  1  borrow-out: 1 iff unsigned a < b + b_in
zero  output  1  diff == 0
ovf  output  1  signed overflow

Behaviour:
- Clock and reset:
  - One clock. Reset is asynchronous and active-low.
  - While rst_n = 0: state = IDLE, in_ready = 1, out_valid = 0, diff = 0, b_out = 0, zero = 0, ovf = 0, slice counter = 0.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid = 1: capture a, b and b_in into operand registers, clear the result register, load borrow = b_in, counter = 0, go to CALC.
  - Input values while in_valid = 0 are ignored.
- CALC:
  - in_ready = 0; in_valid is ignored.
  - Each edge computes slice k = counter (bits k*SLICE .. k*SLICE+SLICE-1) as a_slice - b_slice - borrow.
  - The slice result is written into diff bits; the slice borrow-out goes to the borrow register; counter increments.
  - After slice N-1 (N = WIDTH/SLICE = 8 by default), go to DONE on that same edge.
  - At that edge, also update outputs: b_out = final borrow, zero = (diff == 0), ovf = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]).
- DONE:
  - out_valid = 1; diff and flags are stable.
  - On an edge with out_ready = 1: go to IDLE and drop out_valid. in_ready is high in the following cycle.
  - While out_ready = 0, all outputs are held indefinitely.
- Latency and throughput:
  - Accept edge E0; out_valid is visible after edge E0+N (8 edges after accept).
  - Throughput is one result per N+2 cycles minimum. There is no overlap of operations.
- Outputs:
  - diff and the flags are valid only while out_valid = 1.
  - They keep their last value (or partial value during CALC) otherwise; the bench checks them only under out_valid.
- Boundary conditions:
  - Reset mid-CALC or mid-DONE aborts the operation immediately. No partial result is ever flagged valid.
  - Borrow propagates across all slices: a full-width borrow ripple (0 - 1) must produce all ones.
  - b_in = 1 with a == b gives diff = all ones and b_out = 1.
  - out_ready high while not in DONE has no effect.

Optional Feature:
- Macro: SUB_ADD_MODE_EN.
- When defined:
  - Adds input port op (1 bit, captured with the operands).
  - op = 0 gives subtraction as specified above.
  - op = 1 computes diff = a + b + b_in. b_out then reports carry-out, and ovf = (a[W-1] == b[W-1]) && (diff[W-1] != a[W-1]). Latency is identical.
- When undefined: the op port is absent and the block only subtracts.

Test Plan:
- Reset: hold rst_n = 0 -> in_ready = 1, out_valid = 0, diff = 0, flags = 0. Assert rst_n = 0 three cycles into CALC -> out_valid never rises, in_ready = 1 immediately.
- a = 0x00000005, b = 0x00000003, b_in = 0 -> diff = 0x00000002, b_out = 0, zero = 0, ovf = 0. out_valid rises exactly 8 edges after the accept edge.
- a = 0x00000000, b = 0x00000001, b_in = 0 -> diff = 0xFFFFFFFF, b_out = 1, ovf = 0 (full borrow ripple).
- a = 0x80000000, b = 0x00000001, b_in = 0 -> diff = 0x7FFFFFFF, b_out = 0, ovf = 1.
- a = 0x00010000, b = 0x0000FFFF, b_in = 1 -> diff = 0x00000000, zero = 1, b_out = 0. Also a = b = 0x12345678 with b_in = 1 -> diff = 0xFFFFFFFF, b_out = 1.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE while toggling in_valid and operands -> outputs stable, in_ready = 0, no new capture. Then out_ready = 1 -> IDLE next cycle and a back-to-back operation completes correctly. With SUB_ADD_MODE_EN defined, op = 1, a = 0xFFFFFFFF, b = 0x00000001 -> diff = 0, b_out = 1.
